// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a mid-bit sampler and a small show-ahead FIFO drained by valid/ready.
// A stop bit sampled low raises one ferr pulse and parks in BREAK until the line returns high.
module uart_rx_fifo #(
  parameter int unsigned CLK_PER_BIT = 1085,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rdata,
  output logic       rvalid,
  input  logic       rready,
  output logic       ferr,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CW = $clog2(CLK_PER_BIT);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BitEnd  = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] HalfEnd = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [AW:0]   Full    = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          rxd_q, rxd_s;
  logic          push_req, ferr_d;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0]   count_q;
  logic          ferr_q, overrun_q;
  logic          full, pop, do_push, overrun_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_q <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_q <= rxd;
      rxd_s <= rxd_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    push_req = 1'b0;
    ferr_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rxd_s) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        // A start bit that is high again at its centre is treated as a glitch.
        if (cnt_q == HalfEnd) begin
          cnt_d = '0;
          idx_d = '0;
          state_d = rxd_s ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == BitEnd) begin
          shift_d[idx_q] = rxd_s;
          cnt_d = '0;
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = StStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == BitEnd) begin
          if (rxd_s) begin
            push_req = 1'b1;
            state_d  = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StBreak;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StBreak: begin
        if (rxd_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign full   = (count_q == Full);
  assign rvalid = (count_q != '0);
  assign pop    = rvalid & rready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push   = push_req & (~full | pop);
  assign overrun_d = push_req & full & ~pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      ferr_q    <= ferr_d;
      overrun_q <= overrun_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (!do_push && pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  assign rdata   = rvalid ? mem[rd_ptr_q] : 8'h00;
  assign ferr    = ferr_q;
  assign overrun = overrun_q;
  assign busy    = (state_q != StIdle);

endmodule
